control_sequencer: RTL and testbench

Hardwired control unit for the 16-bit processor. It sequences each instruction through fetch, decode and execute micro-steps. It drives the instruction-register load strobe (`ldir`), the 6-bit micro-step code, and all datapath and memory controls. It sits between the instruction register (the source of `ir_opcode`) and the datapath registers, bus and ALU, and it is the only master of the shared bus.

---
 rtl/ctrl_pkg.sv | 101 ++++++++++
 rtl/ctrl_out_decode.sv | 133 +++++++++++++
 rtl/control_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//
// Shared definitions for the hardwired control sequencer of the 16-bit
// processor.
//
// Contents:
//   - opcode values understood by the sequencer
//   - state / micro-step codes (these are also the values seen on `step`)
//   - bus source and ALU operation encodings
//   - the packed strobe vector produced by the output decoder
//   - small opcode classification helpers
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Width of the opcode field inside the sequencer.
    localparam int OPCODE_W = 6;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LDAC = 6'h01;
    localparam logic [OPCODE_W-1:0] OP_STAC = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_JMPZ = 6'h06;
    localparam logic [OPCODE_W-1:0] OP_INC  = 6'h07;
    localparam logic [OPCODE_W-1:0] OP_MVR  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_HALT = 6'h3F;

    // Sequencer states. The encoding is exported unchanged as the
    // micro-step code, so the values are fixed rather than left to the tools.
    typedef enum logic [5:0] {
        ST_IDLE = 6'd0,
        ST_F1   = 6'd1,
        ST_F2   = 6'd2,
        ST_F3   = 6'd3,
        ST_DEC  = 6'd4,
        ST_E1   = 6'd8,
        ST_E2   = 6'd9,
        ST_E3   = 6'd10,
        ST_E4   = 6'd11,
        ST_E5   = 6'd12,
        ST_HALT = 6'd63
    } state_t;

    // Shared bus source select.
    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_DR   = 3'd2,
        BUS_AC   = 3'd3,
        BUS_R    = 3'd4,
        BUS_MEM  = 3'd5
    } bus_sel_t;

    // ALU operation select.
    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2,
        ALU_INC  = 2'd3
    } alu_op_t;

    // Every control line the sequencer drives besides `step`.
    typedef struct packed {
        logic     ldir;
        bus_sel_t bus_sel;
        logic     ld_ar;
        logic     ld_pc;
        logic     inc_pc;
        logic     ld_dr;
        logic     ld_ac;
        logic     ld_r;
        logic     mem_rd;
        logic     mem_wr;
        alu_op_t  alu_op;
        logic     busy;
        logic     halted;
        logic     illegal;
    } ctrl_strobes_t;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_LDAC, OP_STAC, OP_ADD, OP_SUB,
            OP_JMP, OP_JMPZ, OP_INC, OP_MVR, OP_HALT: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for opcodes whose execute phase starts with an operand read
    // (E1 addresses the word after the instruction, E2 reads it into DR).
    // A taken JMPZ has already been rewritten to JMP before this is used.
    function automatic logic uses_operand(input logic [OPCODE_W-1:0] op);
        return (op == OP_LDAC) || (op == OP_STAC) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// ----------------------------------------------------------------------------
// ctrl_out_decode
//
// Purely combinational map from the sequencer state, the opcode being
// executed and the memory handshake to the full strobe vector.
//
// Ports:
//   state    in   current sequencer state
//   opcode   in   opcode to decode: the live IR opcode while in DEC, the
//                 registered (possibly rewritten) opcode in execute steps
//   mem_rdy  in   memory completes the current access this cycle
//   strobes  out  all datapath, memory and status controls
//
// Outputs are Moore-style except the DR load and PC increment that finish
// a memory read; those are qualified by mem_rdy so they fire exactly once,
// on the cycle the data is actually on the bus.
// ----------------------------------------------------------------------------
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t                state,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  mem_rdy,
    output ctrl_strobes_t         strobes
);

    // Start from all-quiet and switch on only what the current micro-step
    // needs. Reads keep mem_rd and the memory bus source up for the whole
    // wait; writes keep mem_wr and the AC source up for the whole wait.
    always_comb begin
        strobes      = '0;
        strobes.busy = (state != ST_IDLE) && (state != ST_HALT);

        case (state)
            ST_F1: begin
                strobes.bus_sel = BUS_PC;
                strobes.ld_ar   = 1'b1;
            end

            ST_F2: begin
                strobes.bus_sel = BUS_MEM;
                strobes.mem_rd  = 1'b1;
                strobes.ld_dr   = mem_rdy;
                strobes.inc_pc  = mem_rdy;
            end

            ST_F3: begin
                strobes.ldir = 1'b1;
            end

            ST_DEC: begin
                strobes.illegal = !is_legal_opcode(opcode);
            end

            ST_E1: begin
                if (uses_operand(opcode)) begin
                    strobes.bus_sel = BUS_PC;
                    strobes.ld_ar   = 1'b1;
                end else begin
                    case (opcode)
                        OP_ADD: begin
                            strobes.bus_sel = BUS_R;
                            strobes.alu_op  = ALU_ADD;
                            strobes.ld_ac   = 1'b1;
                        end
                        OP_SUB: begin
                            strobes.bus_sel = BUS_R;
                            strobes.alu_op  = ALU_SUB;
                            strobes.ld_ac   = 1'b1;
                        end
                        OP_INC: begin
                            strobes.alu_op  = ALU_INC;
                            strobes.ld_ac   = 1'b1;
                        end
                        OP_MVR: begin
                            strobes.bus_sel = BUS_AC;
                            strobes.ld_r    = 1'b1;
                        end
                        OP_JMPZ: begin
                            // Branch not taken: step the PC over the operand.
                            strobes.inc_pc  = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_E2: begin
                // A jump overwrites the PC in E3, so the operand read must not
                // bump it.
                strobes.bus_sel = BUS_MEM;
                strobes.mem_rd  = 1'b1;
                strobes.ld_dr   = mem_rdy;
                strobes.inc_pc  = mem_rdy && (opcode != OP_JMP);
            end

            ST_E3: begin
                strobes.bus_sel = BUS_DR;
                if (opcode == OP_JMP) begin
                    strobes.ld_pc = 1'b1;
                end else begin
                    strobes.ld_ar = 1'b1;
                end
            end

            ST_E4: begin
                if (opcode == OP_LDAC) begin
                    strobes.bus_sel = BUS_MEM;
                    strobes.mem_rd  = 1'b1;
                    strobes.ld_dr   = mem_rdy;
                end else if (opcode == OP_STAC) begin
                    strobes.bus_sel = BUS_AC;
                    strobes.mem_wr  = 1'b1;
                end
            end

            ST_E5: begin
                strobes.bus_sel = BUS_DR;
                strobes.alu_op  = ALU_PASS;
                strobes.ld_ac   = 1'b1;
            end

            ST_HALT: begin
                strobes.halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit of the 16-bit processor. Walks each instruction
// through fetch (F1..F3), decode (DEC) and up to five execute steps
// (E1..E5), and is the only master of the shared bus.
//
// Parameters:
//   INSTRUCTION_LEN  opcode width and micro-step code width (default 6)
//   DATA_LEN         datapath word width; bounds the opcode field taken
//                    from ir_opcode (default 16)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   run        in   start request, looked at only in IDLE
//   ir_opcode  in   opcode from the instruction register, sampled in DEC
//   z_flag     in   accumulator-zero flag, sampled in DEC (JMPZ)
//   mem_rdy    in   memory finishes the current read/write this cycle
//   step       out  current micro-step code (state encoding)
//   ldir       out  load IR from DR
//   bus_sel    out  bus source: 0 none, 1 PC, 2 DR, 3 AC, 4 R, 5 MEM
//   ld_ar, ld_pc, inc_pc, ld_dr, ld_ac, ld_r   out  register strobes
//   mem_rd, mem_wr   out  memory request, held until mem_rdy
//   alu_op     out  0 pass, 1 add, 2 sub, 3 inc
//   busy       out  high outside IDLE and HALT
//   halted     out  high in HALT
//   illegal    out  one-cycle pulse in DEC for an unknown opcode
// ----------------------------------------------------------------------------
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int INSTRUCTION_LEN = 6,
    parameter int DATA_LEN        = 16
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic [INSTRUCTION_LEN-1:0]  ir_opcode,
    input  logic                        z_flag,
    input  logic                        mem_rdy,
    output logic [INSTRUCTION_LEN-1:0]  step,
    output logic                        ldir,
    output logic [2:0]                  bus_sel,
    output logic                        ld_ar,
    output logic                        ld_pc,
    output logic                        inc_pc,
    output logic                        ld_dr,
    output logic                        ld_ac,
    output logic                        ld_r,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic [1:0]                  alu_op,
    output logic                        busy,
    output logic                        halted,
    output logic                        illegal
);

    // The opcode field can never be wider than the IR word it comes from.
    localparam int OPCODE_MSB = (INSTRUCTION_LEN < DATA_LEN) ? INSTRUCTION_LEN - 1
                                                             : DATA_LEN - 1;

    state_t               state;
    state_t               state_next;
    logic [OPCODE_W-1:0]  exec_op;
    logic [OPCODE_W-1:0]  dec_op;
    logic [OPCODE_W-1:0]  dec_exec_op;
    logic [OPCODE_W-1:0]  decode_op;
    ctrl_strobes_t        strobes;

    assign dec_op = OPCODE_W'(ir_opcode[OPCODE_MSB:0]);

    // Work out, in DEC, which opcode the execute steps should actually
    // follow. Unknown opcodes run as NOP; a JMPZ whose condition holds runs
    // exactly like JMP, so later steps never have to look at z_flag again.
    always_comb begin
        dec_exec_op = dec_op;
        if (!is_legal_opcode(dec_op)) begin
            dec_exec_op = OP_NOP;
        end else if ((dec_op == OP_JMPZ) && z_flag) begin
            dec_exec_op = OP_JMP;
        end
    end

    // State register plus the opcode captured at the end of DEC. Reset is
    // asynchronous, so an outstanding memory request disappears the moment
    // rst_n falls, because every output is decoded from this register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            exec_op <= OP_NOP;
        end else begin
            state <= state_next;
            if (state == ST_DEC) begin
                exec_op <= dec_exec_op;
            end
        end
    end

    // Next-state logic. Memory wait states (F2, E2, E4) hold until mem_rdy;
    // every other step lasts one cycle. The final execute step of every
    // instruction goes back to F1.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_F1;
                end
            end
            ST_F1: state_next = ST_F2;
            ST_F2: begin
                if (mem_rdy) begin
                    state_next = ST_F3;
                end
            end
            ST_F3: state_next = ST_DEC;
            ST_DEC: begin
                if (dec_op == OP_HALT) begin
                    state_next = ST_HALT;
                end else if (dec_exec_op == OP_NOP) begin
                    state_next = ST_F1;
                end else begin
                    state_next = ST_E1;
                end
            end
            ST_E1: begin
                if (uses_operand(exec_op)) begin
                    state_next = ST_E2;
                end else begin
                    state_next = ST_F1;
                end
            end
            ST_E2: begin
                if (mem_rdy) begin
                    state_next = ST_E3;
                end
            end
            ST_E3: begin
                if (exec_op == OP_JMP) begin
                    state_next = ST_F1;
                end else begin
                    state_next = ST_E4;
                end
            end
            ST_E4: begin
                if (mem_rdy) begin
                    state_next = (exec_op == OP_LDAC) ? ST_E5 : ST_F1;
                end
            end
            ST_E5:   state_next = ST_F1;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // DEC has no registered opcode yet, so the decoder sees the live IR
    // value there (only to flag illegal opcodes).
    assign decode_op = (state == ST_DEC) ? dec_op : exec_op;

    ctrl_out_decode u_out_decode (
        .state   (state),
        .opcode  (decode_op),
        .mem_rdy (mem_rdy),
        .strobes (strobes)
    );

    assign step    = INSTRUCTION_LEN'(state);
    assign ldir    = strobes.ldir;
    assign bus_sel = strobes.bus_sel;
    assign ld_ar   = strobes.ld_ar;
    assign ld_pc   = strobes.ld_pc;
    assign inc_pc  = strobes.inc_pc;
    assign ld_dr   = strobes.ld_dr;
    assign ld_ac   = strobes.ld_ac;
    assign ld_r    = strobes.ld_r;
    assign mem_rd  = strobes.mem_rd;
    assign mem_wr  = strobes.mem_wr;
    assign alu_op  = strobes.alu_op;
    assign busy    = strobes.busy;
    assign halted  = strobes.halted;
    assign illegal = strobes.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench for control_sequencer. A trace generator turns each
// instruction (opcode, z flag, memory wait counts) into the list of cycles
// it must take and the control lines each cycle must show; the driver
// replays the list and one compare process checks every cycle. Literal
// expectations from hand-worked examples pin the trace generator itself.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_sequencer;

    // Output vector layout: {step[5:0], bus[2:0], alu[1:0], flags[11:0]}
    localparam logic [11:0] F_LDIR   = 12'h800;
    localparam logic [11:0] F_LDAR   = 12'h400;
    localparam logic [11:0] F_LDPC   = 12'h200;
    localparam logic [11:0] F_INCPC  = 12'h100;
    localparam logic [11:0] F_LDDR   = 12'h080;
    localparam logic [11:0] F_LDAC   = 12'h040;
    localparam logic [11:0] F_LDR    = 12'h020;
    localparam logic [11:0] F_MRD    = 12'h010;
    localparam logic [11:0] F_MWR    = 12'h008;
    localparam logic [11:0] F_BUSY   = 12'h004;
    localparam logic [11:0] F_HALTED = 12'h002;
    localparam logic [11:0] F_ILL    = 12'h001;

    localparam int B_NONE = 0, B_PC = 1, B_DR = 2, B_AC = 3, B_R = 4, B_MEM = 5;

    localparam logic [5:0] C_NOP = 6'h00, C_LDAC = 6'h01, C_STAC = 6'h02,
                           C_ADD = 6'h03, C_SUB = 6'h04, C_JMP = 6'h05,
                           C_JMPZ = 6'h06, C_INC = 6'h07, C_MVR = 6'h08,
                           C_HALT = 6'h3F;

    typedef struct {
        logic        rdy;
        logic        run_v;
        logic [5:0]  op;
        logic        z;
        logic [22:0] exp;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [5:0]  ir_opcode;
    logic        z_flag;
    logic        mem_rdy;
    logic [5:0]  step;
    logic        ldir;
    logic [2:0]  bus_sel;
    logic        ld_ar, ld_pc, inc_pc, ld_dr, ld_ac, ld_r;
    logic        mem_rd, mem_wr;
    logic [1:0]  alu_op;
    logic        busy, halted, illegal;

    logic [22:0] dut_vec;
    logic [22:0] exp_cur;
    logic        exp_valid;
    entry_t      plan[$];
    logic [22:0] vec_log[$];
    int          checks;
    int          errors;

    logic [5:0]  b_op;
    logic        b_z;
    logic        b_post;

    control_sequencer #(
        .INSTRUCTION_LEN (6),
        .DATA_LEN        (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .ir_opcode (ir_opcode),
        .z_flag    (z_flag),
        .mem_rdy   (mem_rdy),
        .step      (step),
        .ldir      (ldir),
        .bus_sel   (bus_sel),
        .ld_ar     (ld_ar),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .ld_dr     (ld_dr),
        .ld_ac     (ld_ac),
        .ld_r      (ld_r),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .alu_op    (alu_op),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    assign dut_vec = {step, bus_sel, alu_op, ldir, ld_ar, ld_pc, inc_pc, ld_dr,
                      ld_ac, ld_r, mem_rd, mem_wr, busy, halted, illegal};

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [22:0] actual,
                                input logic [22:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Expected outputs for one cycle; busy/halted follow from the step.
    function automatic logic [22:0] ev(input int st, input int bus, input int alu,
                                       input logic [11:0] flags);
        logic [11:0] f;
        f = flags;
        if (st != 0 && st != 63) f = f | F_BUSY;
        if (st == 63)            f = f | F_HALTED;
        return {6'(st), 3'(bus), 2'(alu), f};
    endfunction

    function automatic logic known_op(input logic [5:0] op);
        return (op <= 6'h08) || (op == C_HALT);
    endfunction

    task automatic add(input logic rdy, input int st, input int bus, input int alu,
                       input logic [11:0] flags);
        entry_t e;
        e.rdy   = rdy;
        e.run_v = 1'b0;
        // After DEC the IR inputs are scrambled: the DUT must have latched them.
        e.op    = b_post ? (b_op ^ 6'h15) : b_op;
        e.z     = b_post ? ~b_z : b_z;
        e.exp   = ev(st, bus, alu, flags);
        plan.push_back(e);
    endtask

    // A memory access: 'waits' cycles with mem_rdy low, then the finishing cycle.
    task automatic add_wait(input int st, input int bus, input logic [11:0] base,
                            input logic [11:0] done, input int waits);
        for (int i = 0; i < waits; i++) add(1'b0, st, bus, 0, base);
        add(1'b1, st, bus, 0, base | done);
    endtask

    task automatic add_idle_start();
        b_op = C_NOP; b_z = 1'b0; b_post = 1'b0;
        add(1'b1, 0, B_NONE, 0, 12'h000);
        plan[plan.size()-1].run_v = 1'b1;
    endtask

    task automatic add_halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            add(1'b1, 63, B_NONE, 0, 12'h000);
            plan[plan.size()-1].run_v = i[0];
        end
    endtask

    // Trace of one instruction from F1 to its last execute step.
    task automatic build_instr(input logic [5:0] op, input logic z, input int f2w,
                               input int e2w, input int e4w);
        logic jump;
        b_op = op; b_z = z; b_post = 1'b0;
        jump = (op == C_JMP) || (op == C_JMPZ && z);
        add(1'b1, 1, B_PC, 0, F_LDAR);
        add_wait(2, B_MEM, F_MRD, F_LDDR | F_INCPC, f2w);
        add(1'b1, 3, B_NONE, 0, F_LDIR);
        add(1'b1, 4, B_NONE, 0, known_op(op) ? 12'h000 : F_ILL);
        b_post = 1'b1;
        if (op == C_LDAC || op == C_STAC || jump) begin
            add(1'b1, 8, B_PC, 0, F_LDAR);
            add_wait(9, B_MEM, F_MRD, jump ? F_LDDR : (F_LDDR | F_INCPC), e2w);
            add(1'b1, 10, B_DR, 0, jump ? F_LDPC : F_LDAR);
            if (op == C_LDAC) begin
                add_wait(11, B_MEM, F_MRD, F_LDDR, e4w);
                add(1'b1, 12, B_DR, 0, F_LDAC);
            end else if (op == C_STAC) begin
                add_wait(11, B_AC, F_MWR, 12'h000, e4w);
            end
        end else begin
            case (op)
                C_ADD:  add(1'b1, 8, B_R, 1, F_LDAC);
                C_SUB:  add(1'b1, 8, B_R, 2, F_LDAC);
                C_INC:  add(1'b1, 8, B_NONE, 3, F_LDAC);
                C_MVR:  add(1'b1, 8, B_AC, 0, F_LDR);
                C_JMPZ: add(1'b1, 8, B_NONE, 0, F_INCPC);
                default: begin
                end
            endcase
        end
    endtask

    // Replays the planned cycles; inputs change 1 ns after the rising edge.
    task automatic apply_stimulus();
        foreach (plan[i]) begin
            @(posedge clk); #1;
            mem_rdy   = plan[i].rdy;
            run       = plan[i].run_v;
            ir_opcode = plan[i].op;
            z_flag    = plan[i].z;
            exp_cur   = plan[i].exp;
            exp_valid = 1'b1;
        end
        @(posedge clk); #1;
        exp_valid = 1'b0;
        run       = 1'b0;
        plan.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; mem_rdy = 1'b1; ir_opcode = 6'h00; z_flag = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_outputs", dut_vec, 23'd0);
        rst_n = 1'b1;
        vec_log.delete();
    endtask

    // Single compare process: every planned cycle is checked on the falling edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            vec_log.push_back(dut_vec);
            check_output($sformatf("trace step=%0d", exp_cur[22:17]), dut_vec, exp_cur);
        end
    end

    initial begin
        int seq[7];
        int cnt;
        int cycles;
        checks = 0; errors = 0; exp_valid = 1'b0; exp_cur = '0;
        b_op = 6'h00; b_z = 1'b0; b_post = 1'b0;

        // ADD from IDLE, memory always ready.
        do_reset();
        add_idle_start();
        build_instr(C_ADD, 1'b0, 0, 0, 0);
        build_instr(C_NOP, 1'b0, 0, 0, 0);
        apply_stimulus();
        seq = '{0, 1, 2, 3, 4, 8, 1};
        for (int i = 0; i < 7; i++)
            check_output($sformatf("add_step_%0d", i), 23'(vec_log[i][22:17]), 23'(seq[i]));
        cnt = 0;
        for (int i = 0; i < 6; i++) if (vec_log[i][11]) cnt++;
        check_output("add_ldir_count", 23'(cnt), 23'd1);
        check_output("add_ldir_at_f3", 23'(vec_log[3][11]), 23'd1);
        check_output("add_e1_ldac_alu", 23'({vec_log[5][13:12], vec_log[5][6]}), 23'(3'b011));

        // LDAC with two-cycle waits on the fetch and the data read.
        do_reset();
        add_idle_start();
        build_instr(C_LDAC, 1'b0, 2, 0, 2);
        build_instr(C_NOP, 1'b0, 0, 0, 0);
        apply_stimulus();
        cycles = -1;
        for (int j = 2; j < vec_log.size(); j++) begin
            if (cycles < 0 && vec_log[j][22:17] == 6'd1) cycles = j - 1;
        end
        check_output("ldac_cycles", 23'(cycles), 23'd13);
        cnt = 0;
        for (int j = 1; j < 14; j++) if (vec_log[j][7]) cnt++;
        check_output("ldac_lddr_count", 23'(cnt), 23'd3);
        cnt = 0;
        for (int j = 1; j < 14; j++) if (vec_log[j][4]) cnt++;
        check_output("ldac_memrd_cycles", 23'(cnt), 23'd7);

        // Branches, ALU ops, store, illegal opcode, then HALT with run toggling.
        do_reset();
        add_idle_start();
        build_instr(C_JMPZ, 1'b0, 0, 0, 0);
        build_instr(C_JMPZ, 1'b1, 1, 1, 0);
        build_instr(C_SUB,  1'b0, 0, 0, 0);
        build_instr(C_INC,  1'b1, 0, 0, 0);
        build_instr(C_MVR,  1'b0, 0, 0, 0);
        build_instr(C_STAC, 1'b0, 0, 1, 1);
        build_instr(C_JMP,  1'b0, 0, 0, 0);
        build_instr(6'h2A,  1'b0, 0, 0, 0);
        build_instr(C_NOP,  1'b1, 0, 0, 0);
        build_instr(C_HALT, 1'b0, 0, 0, 0);
        add_halt_cycles(4);
        apply_stimulus();
        cnt = 0;
        foreach (vec_log[j]) if (vec_log[j][0]) cnt++;
        check_output("illegal_pulse_count", 23'(cnt), 23'd1);
        check_output("halt_final", 23'({vec_log[vec_log.size()-1][22:17],
                                        vec_log[vec_log.size()-1][2:1]}), 23'({6'd63, 2'b01}));

        // Reset asserted while STAC is waiting on its write.
        do_reset();
        add_idle_start();
        build_instr(C_STAC, 1'b0, 0, 0, 3);
        repeat (3) void'(plan.pop_back());
        apply_stimulus();
        #2;
        check_output("stac_e4_wr_pending", 23'({step, mem_wr}), 23'({6'd11, 1'b1}));
        rst_n = 1'b0;
        #1;
        check_output("async_reset_drop", dut_vec, 23'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output($sformatf("idle_after_reset_%0d", i), dut_vec, 23'd0);
        end
        @(posedge clk); #1; run = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        @(negedge clk);
        check_output("run_to_f1", 23'(step), 23'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
